// File: rtl/addsub_seq_ctrl.sv
// Byte-serial WIDTH-bit add/subtract built around one 8-bit adder slice, LSB byte first.
// Result is valid BYTES cycles after acceptance; result is held in DONE until out_ready is seen.

module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

module addsub_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int BYTES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             sub_q, sub_d, cy_q, cy_d, ovf_q, ovf_d;

  logic [7:0] add_a, add_b, add_sum;
  logic       add_cout;

  assign add_a = a_q[8*cnt_q +: 8];
  assign add_b = b_q[8*cnt_q +: 8] ^ {8{sub_q}};

  adder_8bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (cy_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    cy_d    = cy_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          cnt_d   = '0;
          cy_d    = op_sub;
        end
      end
      RUN: begin
        res_d[8*cnt_q +: 8] = add_sum;
        cy_d                = add_cout;
        if (cnt_q == LAST) begin
          // add_b already carries the inversion, so this is the subtract-aware sign check
          ovf_d   = (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry     = cy_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed checks of the byte-serial add/sub sequencer at WIDTH=32 and WIDTH=8.
module tb_addsub_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;
  logic        in_valid, op_sub;
  logic [31:0] a, b;
  logic        in_ready, out_valid, carry, overflow;
  logic [31:0] result;
  logic        in_valid8, op_sub8;
  logic [7:0]  a8, b8;
  logic        in_ready8, out_valid8, carry8, overflow8;
  logic [7:0]  result8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  addsub_seq_ctrl #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .overflow(overflow)
  );

  addsub_seq_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op_sub(op_sub8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready), .result(result8),
    .carry(carry8), .overflow(overflow8)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one 32-bit operation and check latency, outputs, hold behaviour and release.
  task automatic op32(input logic [31:0] ta, input logic [31:0] tb_, input logic tsub,
                      input logic [31:0] er, input logic ec, input logic eo,
                      input int hold, input bit disturb, input string tag);
    int lat;
    @(negedge clk);
    a = ta; b = tb_; op_sub = tsub; in_valid = 1'b1;
    chk({31'b0, in_ready}, 32'd1, {tag, " in_ready"});
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (disturb && lat == 1) begin
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; op_sub = ~tsub; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk(lat, 32'd4, {tag, " latency"});
    chk(result, er, {tag, " result"});
    chk({31'b0, carry}, {31'b0, ec}, {tag, " carry"});
    chk({31'b0, overflow}, {31'b0, eo}, {tag, " overflow"});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({31'b0, out_valid}, 32'd1, {tag, " hold out_valid"});
      chk(result, er, {tag, " hold result"});
      chk({31'b0, in_ready}, 32'd0, {tag, " hold in_ready"});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({31'b0, out_valid}, 32'd0, {tag, " out_valid drop"});
    chk({31'b0, in_ready}, 32'd1, {tag, " in_ready back"});
    chk(result, er, {tag, " result kept in idle"});
  endtask

  initial begin
    int lat;
    rst = 1'b1; out_ready = 1'b0;
    in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    in_valid8 = 1'b0; op_sub8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk({31'b0, in_ready}, 32'd0, "in_ready during rst");
    rst = 1'b0;
    @(negedge clk);
    chk({31'b0, out_valid}, 32'd0, "reset out_valid");
    chk(result, 32'd0, "reset result");
    chk({30'b0, carry, overflow}, 32'd0, "reset carry/ovf");
    chk({31'b0, in_ready}, 32'd1, "reset in_ready");

    op32(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0, 1'b0, "add_ff_1");
    op32(32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 1'b0, "sub_5_7");
    op32(32'd7, 32'd5, 1'b1, 32'd2, 1'b1, 1'b0, 0, 1'b0, "sub_7_5");
    op32(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0, "add_ovf");
    op32(32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 1'b0, "sub_ovf");
    op32(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0, "add_wrap");
    op32(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 5, 1'b1, "bp_disturb");
    repeat (6) begin
      @(negedge clk);
      chk({31'b0, out_valid}, 32'd0, "no extra op");
    end

    // reset on the second RUN step
    @(negedge clk);
    a = 32'h0102_0304; b = 32'h1010_1010; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({31'b0, in_ready}, 32'd0, "mid rst in_ready low");
    rst = 1'b0;
    chk({31'b0, out_valid}, 32'd0, "mid rst out_valid");
    chk(result, 32'd0, "mid rst result");
    chk({30'b0, carry, overflow}, 32'd0, "mid rst carry/ovf");
    #1;
    chk({31'b0, in_ready}, 32'd1, "mid rst in_ready");
    op32(32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 0, 1'b0, "add_3_4");

    // WIDTH=8 instance
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h20; op_sub8 = 1'b0; in_valid8 = 1'b1;
    chk({31'b0, in_ready8}, 32'd1, "w8 in_ready");
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk(lat, 32'd1, "w8 latency");
    chk({24'b0, result8}, 32'h10, "w8 result");
    chk({31'b0, carry8}, 32'd1, "w8 carry");
    chk({31'b0, overflow8}, 32'd0, "w8 overflow");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({31'b0, out_valid8}, 32'd0, "w8 out_valid drop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/addsub_seq_ctrl.md
# addsub_seq_ctrl

Byte-serial add/subtract sequencer that computes a WIDTH-bit `a + b` or `a - b` by stepping one `adder_8bit` slice across the operands, least-significant byte first. The carry is registered between steps. Operands enter and results leave through valid/ready handshakes. The block trades latency for area: wide arithmetic units in the design use one 8-bit adder instead of a full-width carry chain.

## Interface
- `WIDTH`, default 32: operand/result width; must be a multiple of 8 and at least 8.
- `BYTES`, derived as WIDTH/8: number of adder steps per operation; not user-set.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept an operation.
- `op_sub`  in  1  0 selects a+b; 1 selects a−b.
- `a`  in  WIDTH  operand A, unsigned/two's complement.
- `b`  in  WIDTH  operand B.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  sum or difference, modulo 2^WIDTH.
- `carry`  out  1  final carry out. For subtraction, 1 means no borrow (a ≥ b unsigned).
- `overflow`  out  1  signed two's-complement overflow.

## Operation
- State machine with three states: IDLE, RUN, DONE.
  - IDLE → RUN on `in_valid && in_ready`.
  - RUN → DONE after BYTES steps.
  - DONE → IDLE on `out_ready`.
- Acceptance latches `a`, `b` and `op_sub` into internal registers, clears the step counter, and loads the carry register with `op_sub`. Input changes after acceptance have no effect.
- Each RUN step i (i = 0..BYTES−1) drives one `adder_8bit` instance:
  - `a` input: byte i of latched A.
  - `b` input: byte i of latched B, bitwise inverted when `op_sub` = 1.
  - `cin`: the carry register.
  - At the end of the step, the adder `sum` is written into byte i of the result register and the adder `cout` into the carry register.
- Exactly one `adder_8bit` instance; no other adders in the datapath.
- On the final step, the block computes and registers `overflow`:
  - a7 = bit 7 of A's top byte; b7 = bit 7 of the (possibly inverted) B top byte; s7 = bit 7 of the resulting top sum byte.
  - `overflow` = (a7 == b7) && (s7 != a7).
- `in_ready` = 1 only in IDLE and only while `rst` = 0. `in_valid` in RUN or DONE is ignored and not queued.
- `out_valid` = 1 only in DONE. `result`, `carry` and `overflow` stay stable throughout DONE and keep their values in IDLE until the next final step overwrites them.
- Unsigned operand width rules: all arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset (`rst` = 1 at a rising edge) takes effect from any state, including mid-RUN or DONE; the in-flight operation is discarded. After reset:
  - state = IDLE; `in_ready` = 1 once `rst` deasserts.
  - `out_valid` = 0, `result` = 0, `carry` = 0, `overflow` = 0; step counter = 0.
- If acceptance happens at edge k:
  - RUN occupies cycles k..k+BYTES−1, one byte per edge.
  - `out_valid` rises after edge k+BYTES. Latency is BYTES cycles from acceptance to `out_valid`.
- Handshakes:
  - Result transfer occurs at the edge where `out_valid && out_ready`; `out_valid` is 0 in the following cycle.
  - `out_ready` held high in DONE means DONE lasts exactly one cycle.
  - The next acceptance can occur at the edge after the transfer edge. Minimum period is BYTES+2 cycles per operation.
- `out_ready` outside DONE has no effect.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from `in_valid`/`out_ready`.
- Step counter wraps to 0 when RUN exits. The counter never exceeds BYTES−1.

## Test plan
- Add (WIDTH=32): A=0x000000FF, B=0x00000001, op_sub=0 → after 4 cycles `out_valid`=1, `result`=0x00000100, `carry`=0, `overflow`=0; carry must propagate across the byte boundary.
- Subtract with borrow: A=5, B=7, op_sub=1 → `result`=0xFFFFFFFE, `carry`=0, `overflow`=0. Then A=7, B=5 → `result`=2, `carry`=1.
- Overflow cases:
  - A=0x7FFFFFFF, B=1, add → `result`=0x80000000, `overflow`=1, `carry`=0.
  - A=0x80000000, B=1, sub → `result`=0x7FFFFFFF, `overflow`=1, `carry`=1.
  - A=0xFFFFFFFF, B=1, add → `result`=0, `carry`=1, `overflow`=0.
- Back-pressure and ignored inputs:
  - Hold `out_ready`=0 for 5 cycles in DONE → `out_valid` and `result` remain stable; `in_ready`=0.
  - Change `a`/`b` and pulse `in_valid` during RUN → result unaffected, no extra operation.
- Reset mid-operation: assert `rst` for 1 cycle on the 2nd RUN step → next cycle state IDLE, `out_valid`=0, `result`=0, `in_ready`=1. A following add 3+4 returns 7 with normal latency.
- WIDTH=8 build: A=0xF0, B=0x20, add → `result`=0x10, `carry`=1, latency 1 cycle.
